// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

    // Clear-sweep controller states.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;

    // Register index width for a given register count.
    function automatic int addr_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: tracks destinations claimed by multi-cycle
// producers, flags WAW re-issue and looks up busy state for each read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS       = DEFAULT_NUM_REGS,
    parameter  int NUM_READ_PORTS = 2,
    localparam int ADDR_WIDTH     = addr_width(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ready_i,
    input  logic                                 issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]                issue_reg_i,
    input  logic                                 wb_valid_i,
    input  logic [ADDR_WIDTH-1:0]                wb_reg_i,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_idx_i,
    output logic                                 issue_stall_o,
    output logic [NUM_READ_PORTS-1:0]            port_busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic issue_set;
    assign issue_set = ready_i && issue_valid_i && (issue_reg_i != '0);

    // Next busy vector: writeback clears, issue sets; issue applied last so it wins.
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path infers a latch.
        busy_d = busy_q;
        if (ready_i && wb_valid_i) begin
            busy_d[wb_reg_i] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_reg_i] = 1'b1;
        end
    end

    // Busy register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign issue_stall_o = issue_set && busy_q[issue_reg_i];

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port_busy
        assign port_busy_o[p] = ready_i && busy_q[rd_idx_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with x0 hardwired to zero, a power-up
// clear sweep and a busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REGS       = DEFAULT_NUM_REGS,
    parameter  int NUM_READ_PORTS = 2,
    localparam int ADDR_WIDTH     = addr_width(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] readRegister,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] readData,
    output logic [NUM_READ_PORTS-1:0]            readBusy,
    input  logic [ADDR_WIDTH-1:0]                writeRegister,
    input  logic [DATA_WIDTH-1:0]                writeData,
    input  logic                                 regWrite,
    input  logic                                 issueValid,
    input  logic [ADDR_WIDTH-1:0]                issueRegister,
    output logic                                 issueStall,
    output logic                                 ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clear_idx_q;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NUM_READ_PORTS-1:0] sb_busy;

    // Clear-sweep controller: walks every index once after reset, then holds READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clear_idx_q <= '0;
            ready_q     <= 1'b0;
        end else if (state_q == CLEAR) begin
            clear_idx_q <= clear_idx_q + ADDR_WIDTH'(1);
            if (clear_idx_q == LAST_IDX) begin
                state_q <= READY;
                ready_q <= 1'b1;
            end
        end
    end

    assign ready = ready_q;

    // Single write port shared by the sweep (zeros) and architectural writeback.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = writeRegister;
        wr_data = writeData;
        if (!reset) begin
            if (state_q == CLEAR) begin
                wr_en   = 1'b1;
                wr_idx  = clear_idx_q;
                wr_data = '0;
            end else begin
                wr_en = regWrite && (writeRegister != '0);
            end
        end
    end

    // Register array storage.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the sweep defines its contents, keeping it RAM-mappable.
        if (wr_en) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS       (NUM_REGS),
        .NUM_READ_PORTS (NUM_READ_PORTS)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .ready_i       (ready_q),
        .issue_valid_i (issueValid),
        .issue_reg_i   (issueRegister),
        .wb_valid_i    (regWrite),
        .wb_reg_i      (writeRegister),
        .rd_idx_i      (readRegister),
        .issue_stall_o (issueStall),
        .port_busy_o   (sb_busy)
    );

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] rd_idx;
        logic [DATA_WIDTH-1:0] stored;

        assign rd_idx = readRegister[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign stored = (ready_q && (rd_idx != '0)) ? regs_q[rd_idx] : '0;

`ifdef REGFILE_BYPASS_EN
        logic fwd_hit;
        logic issue_hit;

        assign fwd_hit   = ready_q && regWrite && (writeRegister == rd_idx) && (rd_idx != '0);
        assign issue_hit = ready_q && issueValid && (issueRegister == rd_idx);

        assign readData[p*DATA_WIDTH +: DATA_WIDTH] = fwd_hit ? writeData : stored;
        assign readBusy[p] = fwd_hit ? issue_hit : sb_busy[p];
`else
        assign readData[p*DATA_WIDTH +: DATA_WIDTH] = stored;
        assign readBusy[p] = sb_busy[p];
`endif
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport with four read ports.
module tb_regfile_multiport;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NP = 4;
    localparam int AW = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic [NP*AW-1:0]   readRegister;
    logic [NP*DW-1:0]   readData;
    logic [NP-1:0]      readBusy;
    logic [AW-1:0]      writeRegister;
    logic [DW-1:0]      writeData;
    logic               regWrite;
    logic               issueValid;
    logic [AW-1:0]      issueRegister;
    logic               issueStall;
    logic               ready;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_multiport #(
        .DATA_WIDTH     (DW),
        .NUM_REGS       (NR),
        .NUM_READ_PORTS (NP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .readRegister  (readRegister),
        .readData      (readData),
        .readBusy      (readBusy),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .regWrite      (regWrite),
        .issueValid    (issueValid),
        .issueRegister (issueRegister),
        .issueStall    (issueStall),
        .ready         (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input int idx);
        readRegister[p*AW +: AW] = AW'(idx);
    endtask

    function automatic logic [DW-1:0] rd_data(input int p);
        return readData[p*DW +: DW];
    endfunction

    task automatic write_reg(input int idx, input logic [DW-1:0] d);
        writeRegister = AW'(idx);
        writeData     = d;
        regWrite      = 1'b1;
        tick();
        regWrite      = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(NR));
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        readRegister  = '0;
        writeRegister = '0;
        writeData     = '0;
        regWrite      = 1'b0;
        issueValid    = 1'b0;
        issueRegister = '0;

        // Reset state
        tick();
        tick();
        issueValid    = 1'b1;
        issueRegister = AW'(3);
        set_rd(0, 3);
        #1;
        check("reset_ready", ready, 0);
        check("reset_stall", issueStall, 0);
        check("reset_busy", readBusy, 0);
        issueValid = 1'b0;

        // First sweep, with writes and issues that must be ignored while clearing
        reset = 1'b0;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
            if (n == 5) begin
                set_rd(0, 5);
                regWrite      = 1'b1;
                writeRegister = AW'(2);
                writeData     = 32'h0000_0BAD;
                issueValid    = 1'b1;
                issueRegister = AW'(6);
                #1;
                check("sweep_x5_zero", rd_data(0), 0);
                check("sweep_busy_zero", readBusy, 0);
                check("sweep_stall_zero", issueStall, 0);
            end
            if (n == 6) begin
                regWrite   = 1'b0;
                issueValid = 1'b0;
            end
        end
        check("sweep_len", 64'(n), 64'(NR));
        set_rd(0, 2);
        set_rd(1, 6);
        #1;
        check("sweep_write_ignored", rd_data(0), 0);
        check("sweep_issue_ignored", readBusy[1], 0);

        // Contents written before reset are cleared by the next sweep
        write_reg(5, 32'h0000_1111);
        set_rd(0, 5);
        #1;
        check("x5_written", rd_data(0), 32'h0000_1111);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wait_ready("sweep2_len");
        #1;
        check("x5_cleared", rd_data(0), 0);

        // Basic access and x0 hardwiring
        write_reg(7, 32'hDEAD_BEEF);
        write_reg(0, 32'h1234_5678);
        set_rd(0, 7);
        set_rd(1, 0);
        #1;
        check("read_x7", rd_data(0), 32'hDEAD_BEEF);
        check("read_x0", rd_data(1), 0);

        // All ports aliasing one register
        write_reg(31, 32'hA5A5_A5A5);
        for (int p = 0; p < NP; p++) set_rd(p, 31);
        #1;
        for (int p = 0; p < NP; p++) check($sformatf("alias_p%0d", p), rd_data(p), 32'hA5A5_A5A5);

        // Scoreboard
        set_rd(0, 3);
        set_rd(1, 4);
        issueValid    = 1'b1;
        issueRegister = AW'(3);
        #1;
        check("issue_first_stall", issueStall, 0);
        tick();
        check("busy_x3_set", readBusy[0], 1);
        check("waw_stall", issueStall, 1);
        tick();
        issueRegister = AW'(0);
        #1;
        check("x0_no_stall", issueStall, 0);
        issueRegister = AW'(3);
        regWrite      = 1'b1;
        writeRegister = AW'(3);
        writeData     = 32'h0000_0077;
        tick();
        issueValid = 1'b0;
        regWrite   = 1'b0;
        #1;
        check("set_beats_clear", readBusy[0], 1);
        issueValid    = 1'b1;
        issueRegister = AW'(4);
        regWrite      = 1'b1;
        writeRegister = AW'(3);
        tick();
        issueValid = 1'b0;
        regWrite   = 1'b0;
        #1;
        check("diff_idx_clear", readBusy[0], 0);
        check("diff_idx_set", readBusy[1], 1);
        write_reg(4, 32'h0000_0044);
        #1;
        check("wb_alone_clear", readBusy[1], 0);

        // Same-cycle write/read of x9
        write_reg(9, 32'h0000_0033);
        set_rd(0, 9);
        regWrite      = 1'b1;
        writeRegister = AW'(9);
        writeData     = 32'h0000_0055;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", rd_data(0), 32'h0000_0055);
`else
        check("bypass_same_cycle", rd_data(0), 32'h0000_0033);
`endif
        tick();
        regWrite = 1'b0;
        #1;
        check("x9_next_cycle", rd_data(0), 32'h0000_0055);

        // Reset in the middle of a sweep
        issueValid    = 1'b1;
        issueRegister = AW'(12);
        tick();
        issueValid = 1'b0;
        set_rd(0, 12);
        #1;
        check("x12_busy_pre", readBusy[0], 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midsweep_not_ready", ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready("midsweep_len");
        #1;
        check("midsweep_busy_cleared", readBusy[0], 0);
        check("midsweep_data_cleared", rd_data(0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
